// File: rtl/i2c_write_master_if.sv
// Handshake and bus signals of the single-byte I2C write initiator.
// The master modport is the initiator's view; slave is the controller/bench view.
interface i2c_write_master_if;
    logic       start;
    logic [6:0] addr;
    logic [7:0] data;
    logic       sda_in;
    logic       sda_out;
    logic       scl_out;
    logic       busy;
    logic       done;
    logic       ack_err;

    modport master (
        input  start, addr, data, sda_in,
        output sda_out, scl_out, busy, done, ack_err
    );

    modport slave (
        output start, addr, data, sda_in,
        input  sda_out, scl_out, busy, done, ack_err
    );
endinterface

// File: rtl/i2c_write_master.sv
// Single-byte I2C write initiator: START, address+W, ACK, data, ACK, STOP.
// Every bus phase lasts CLK_DIV clk cycles; SDA/SCL come straight from flops.
module i2c_write_master #(
    parameter int CLK_DIV = 2
) (
    input  logic                clk,
    input  logic                reset,
    i2c_write_master_if.master  bus
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, START, ADDR, AACK, DATA, DACK, STOP, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    q, q_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shreg, data_r;
    logic          nack, nack_n;
    logic          ack_err_r, ack_err_n;
    logic          sda_r, scl_r, sda_n, scl_n;
    logic          accept, last_tick;
    logic [1:0]    last_q;

    assign accept    = ((state == IDLE) || (state == DONE)) && bus.start;
    assign last_tick = (cnt == CW'(CLK_DIV - 1));
    assign last_q    = (state == START) ? 2'd1 : (state == STOP) ? 2'd2 : 2'd3;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        q_n       = q;
        bit_n     = bit_idx;
        nack_n    = nack;
        ack_err_n = ack_err_r;
        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (accept) begin
                    state_n   = START;
                    cnt_n     = '0;
                    q_n       = 2'd0;
                    ack_err_n = 1'b0;
                end
            end
            default: begin
                if (!last_tick) begin
                    cnt_n = cnt + CW'(1);
                end else begin
                    cnt_n = '0;
                    // Slave response is taken on the last clk of the second quarter (SCL high).
                    if (((state == AACK) || (state == DACK)) && (q == 2'd1))
                        nack_n = bus.sda_in;
                    if (q != last_q) begin
                        q_n = q + 2'd1;
                    end else begin
                        q_n = 2'd0;
                        case (state)
                            START: begin
                                state_n = ADDR;
                                bit_n   = 3'd7;
                            end
                            ADDR: begin
                                if (bit_idx == 3'd0) state_n = AACK;
                                else                 bit_n   = bit_idx - 3'd1;
                            end
                            AACK: begin
                                if (nack) begin
                                    ack_err_n = 1'b1;
                                    state_n   = STOP;
                                end else begin
                                    state_n = DATA;
                                    bit_n   = 3'd7;
                                end
                            end
                            DATA: begin
                                if (bit_idx == 3'd0) state_n = DACK;
                                else                 bit_n   = bit_idx - 3'd1;
                            end
                            DACK: begin
                                if (nack) ack_err_n = 1'b1;
                                state_n = STOP;
                            end
                            default: state_n = DONE;
                        endcase
                    end
                end
            end
        endcase
    end

    // Pin levels are derived from the upcoming phase so the flops hold them during that phase.
    always_comb begin
        sda_n = 1'b1;
        scl_n = 1'b1;
        case (state_n)
            START: begin
                scl_n = (q_n == 2'd0);
                sda_n = 1'b0;
            end
            ADDR: begin
                scl_n = (q_n == 2'd1) || (q_n == 2'd2);
                sda_n = shreg[bit_n];
            end
            DATA: begin
                scl_n = (q_n == 2'd1) || (q_n == 2'd2);
                sda_n = data_r[bit_n];
            end
            AACK, DACK: begin
                scl_n = (q_n == 2'd1) || (q_n == 2'd2);
                sda_n = 1'b1;
            end
            STOP: begin
                scl_n = (q_n != 2'd0);
                sda_n = (q_n == 2'd2);
            end
            default: begin
                scl_n = 1'b1;
                sda_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            q         <= 2'd0;
            bit_idx   <= 3'd0;
            nack      <= 1'b0;
            ack_err_r <= 1'b0;
            sda_r     <= 1'b1;
            scl_r     <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            q         <= q_n;
            bit_idx   <= bit_n;
            nack      <= nack_n;
            ack_err_r <= ack_err_n;
            sda_r     <= sda_n;
            scl_r     <= scl_n;
        end
    end

    // NOTE: payload registers are only read after a start loads them, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg  <= {bus.addr, 1'b0};
            data_r <= bus.data;
        end
    end

    assign bus.sda_out = sda_r;
    assign bus.scl_out = scl_r;
    assign bus.busy    = (state != IDLE) && (state != DONE);
    assign bus.done    = (state == DONE);
    assign bus.ack_err = ack_err_r;
endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: a quarter-level waveform model fills per-cycle expectations,
// one compare process checks them, and literal pins cover bit order, lengths and ack_err.
module tb_i2c_write_master;
    localparam int D = 2;
    localparam int N = 4096;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    i2c_write_master_if bus();

    i2c_write_master #(.CLK_DIV(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic ev [N];
    logic escl [N];
    logic esda [N];
    logic ebusy [N];
    logic edone [N];
    logic eae_v [N];
    logic eae [N];
    logic drv [N];

    int   mon_busy = 0;
    int   mon_done = 0;
    logic prev_scl = 1'b1;
    logic mon_bits [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void plan_idle(input int from, input int to, input logic ae);
        for (int c = from; c <= to; c++) begin
            ev[c] = 1'b1; escl[c] = 1'b1; esda[c] = 1'b1;
            ebusy[c] = 1'b0; edone[c] = 1'b0;
            eae_v[c] = 1'b1; eae[c] = ae;
            drv[c] = 1'b1;
        end
    endfunction

    // Builds the transaction as a list of {scl,sda} quarters; start is sampled in cycle k.
    function automatic int plan_txn(input int k, input logic [6:0] a, input logic [7:0] d,
                                    input logic anack, input logic dnack);
        logic [1:0] qs [$];
        logic       sin [$];
        logic [7:0] ab;
        int         c;
        ab = {a, 1'b0};
        qs.push_back(2'b10); qs.push_back(2'b00);
        repeat (2) sin.push_back(1'b1);
        for (int i = 7; i >= 0; i--) begin
            qs.push_back({1'b0, ab[i]}); qs.push_back({1'b1, ab[i]});
            qs.push_back({1'b1, ab[i]}); qs.push_back({1'b0, ab[i]});
            repeat (4) sin.push_back(1'b1);
        end
        qs.push_back(2'b01); qs.push_back(2'b11); qs.push_back(2'b11); qs.push_back(2'b01);
        repeat (4) sin.push_back(anack);
        if (!anack) begin
            for (int i = 7; i >= 0; i--) begin
                qs.push_back({1'b0, d[i]}); qs.push_back({1'b1, d[i]});
                qs.push_back({1'b1, d[i]}); qs.push_back({1'b0, d[i]});
                repeat (4) sin.push_back(1'b1);
            end
            qs.push_back(2'b01); qs.push_back(2'b11); qs.push_back(2'b11); qs.push_back(2'b01);
            repeat (4) sin.push_back(dnack);
        end
        qs.push_back(2'b00); qs.push_back(2'b10); qs.push_back(2'b11);
        repeat (3) sin.push_back(1'b1);
        for (int qi = 0; qi < qs.size(); qi++) begin
            for (int j = 0; j < D; j++) begin
                c = k + 1 + qi * D + j;
                ev[c] = 1'b1; escl[c] = qs[qi][1]; esda[c] = qs[qi][0];
                ebusy[c] = 1'b1; edone[c] = 1'b0;
                eae_v[c] = (qi < 2); eae[c] = 1'b0;
                drv[c] = sin[qi];
            end
        end
        c = k + 1 + qs.size() * D;
        ev[c] = 1'b1; escl[c] = 1'b1; esda[c] = 1'b1;
        ebusy[c] = 1'b0; edone[c] = 1'b1;
        eae_v[c] = 1'b1; eae[c] = anack | dnack;
        drv[c] = 1'b1;
        return c;
    endfunction

    // Single compare process against the model.
    always @(negedge clk) begin
        if (cyc < N && ev[cyc]) begin
            check($sformatf("scl@%0d", cyc), bus.scl_out, escl[cyc]);
            check($sformatf("sda@%0d", cyc), bus.sda_out, esda[cyc]);
            check($sformatf("busy@%0d", cyc), bus.busy, ebusy[cyc]);
            check($sformatf("done@%0d", cyc), bus.done, edone[cyc]);
            if (eae_v[cyc]) check($sformatf("ack_err@%0d", cyc), bus.ack_err, eae[cyc]);
        end
    end

    // Bus monitor feeding the literal checks.
    always @(negedge clk) begin
        if (bus.busy) mon_busy++;
        if (bus.done) mon_done++;
        if (!prev_scl && bus.scl_out) mon_bits.push_back(bus.sda_out);
        prev_scl = bus.scl_out;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cyc < N) bus.sda_in = drv[cyc];
        end
    end

    task automatic mon_clear();
        mon_busy = 0;
        mon_done = 0;
        mon_bits.delete();
    endtask

    function automatic logic [7:0] mon_byte(input int off);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++)
            b = {b[6:0], (off + i < mon_bits.size()) ? mon_bits[off + i] : 1'bx};
        return b;
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go(input int at, input logic [6:0] a, input logic [7:0] d,
                      input logic anack, input logic dnack, output int k, output int e);
        wait_until(at);
        k = cyc;
        bus.addr  = a;
        bus.data  = d;
        bus.start = 1'b1;
        e = plan_txn(k, a, d, anack, dnack);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int k, input int e, input int offset);
        int n;
        n = 0;
        while (!bus.done && n < 200 * D) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_timeout", (n < 200 * D), 1);
        check("done_cycle", cyc, e);
        check("done_offset", cyc - k, offset);
    endtask

    int k, e;

    initial begin
        for (int c = 0; c < N; c++) begin
            ev[c] = 1'b0;
            drv[c] = 1'b1;
        end
        bus.start  = 1'b0;
        bus.addr   = 7'h00;
        bus.data   = 8'h00;
        bus.sda_in = 1'b1;
        plan_idle(1, 8, 1'b0);

        // T1: reset held 3 cycles
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check("t1_sda", bus.sda_out, 1);
        check("t1_scl", bus.scl_out, 1);
        check("t1_busy", bus.busy, 0);
        check("t1_done", bus.done, 0);
        check("t1_ack_err", bus.ack_err, 0);
        @(posedge clk);
        #1;

        // T2: full transaction, both ACKs
        mon_clear();
        go(cyc + 1, 7'h50, 8'hA5, 1'b0, 1'b0, k, e);
        wait_done(k, e, 155);
        check("t2_busy_len", mon_busy, 154);
        check("t2_rises", mon_bits.size(), 19);
        check("t2_addr_bits", mon_byte(0), 8'hA0);
        check("t2_data_bits", mon_byte(9), 8'hA5);
        check("t2_ack_err", bus.ack_err, 0);
        plan_idle(e + 1, e + 4, 1'b0);
        wait_until(e + 3);

        // T4: data NACK, then back-to-back start in the done cycle
        mon_clear();
        go(cyc + 1, 7'h2B, 8'h3C, 1'b0, 1'b1, k, e);
        wait_done(k, e, 155);
        check("t4_busy_len", mon_busy, 154);
        check("t4_addr_bits", mon_byte(0), 8'h56);
        check("t4_data_bits", mon_byte(9), 8'h3C);
        check("t4_ack_err", bus.ack_err, 1);

        // T3: address NACK, started in T4's done cycle
        mon_clear();
        go(cyc, 7'h11, 8'hFF, 1'b1, 1'b0, k, e);
        wait_done(k, e, 83);
        check("t3_busy_len", mon_busy, 82);
        check("t3_rises", mon_bits.size(), 10);
        check("t3_addr_bits", mon_byte(0), 8'h22);
        check("t3_ack_err", bus.ack_err, 1);
        plan_idle(e + 1, e + 6, 1'b1);
        wait_until(e + 5);
        check("t3_ack_err_hold", bus.ack_err, 1);

        // T5: start and payload changes mid-transaction are ignored
        mon_clear();
        go(cyc + 1, 7'h3C, 8'h5A, 1'b0, 1'b0, k, e);
        wait_until(k + 40);
        bus.start = 1'b1;
        bus.addr  = 7'h7F;
        bus.data  = 8'hFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(k, e, 155);
        check("t5_busy_len", mon_busy, 154);
        check("t5_addr_bits", mon_byte(0), 8'h78);
        check("t5_data_bits", mon_byte(9), 8'h5A);
        plan_idle(e + 1, e + 6, 1'b0);
        wait_until(e + 3);
        check("t5_done_pulses", mon_done, 1);

        // T6: reset in the middle of a transaction, then a clean one
        go(cyc + 1, 7'h50, 8'hA5, 1'b0, 1'b0, k, e);
        wait_until(k + 60);
        reset = 1'b0;
        for (int c = k + 61; c < k + 200; c++) begin
            ev[c] = 1'b0;
            drv[c] = 1'b1;
        end
        plan_idle(k + 61, k + 66, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("t6_sda", bus.sda_out, 1);
        check("t6_scl", bus.scl_out, 1);
        check("t6_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        mon_clear();
        go(cyc + 1, 7'h50, 8'hA5, 1'b0, 1'b0, k, e);
        wait_done(k, e, 155);
        check("t6_busy_len", mon_busy, 154);
        check("t6_addr_bits", mon_byte(0), 8'hA0);
        check("t6_data_bits", mon_byte(9), 8'hA5);
        plan_idle(e + 1, e + 4, 1'b0);
        wait_until(e + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
